// File: rtl/s2m_pipe.sv
// s2m_pipe: ready-path register slice (skid buffer) for a valid/ready stream.
// pipe_in_ready comes straight from a flop, so the downstream ready never
// reaches the upstream ready combinationally. A single skid register holds
// the beat that was already in flight when downstream stalled. While the skid
// is empty, valid and data pass straight through with no added latency.
module s2m_pipe #(
  parameter int DATA_WIDTH = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_in_valid,
  input  logic [DATA_WIDTH-1:0] pipe_in_data,
  output logic                  pipe_in_ready,
  output logic                  pipe_out_valid,
  output logic [DATA_WIDTH-1:0] pipe_out_data,
  input  logic                  pipe_out_ready,
  output logic                  skid_full,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  // PASS: the skid is empty and the stream flows through.
  // SKID: the skid holds one beat and upstream is held off.
  typedef enum logic {
    ST_PASS = 1'b0,
    ST_SKID = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_in_ready;
  logic                  w_in_ready_next;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;

  logic                  w_in_xfer;
  logic                  w_skid_load;
  logic                  w_cnt_max;

  // An input beat is accepted only while the registered ready is high.
  // The ready flop is low in SKID, so acceptance implies PASS.
  assign w_in_xfer   = pipe_in_valid & r_in_ready;
  // Capture into the skid when a beat is accepted but downstream cannot take it.
  assign w_skid_load = (r_state == ST_PASS) & w_in_xfer & ~pipe_out_ready;
  assign w_cnt_max   = &r_stall_cnt;

  // State register and the registered upstream ready.
  // Ready resets low and rises on the first edge after reset deasserts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_PASS;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= w_in_ready_next;
    end
  end

  // Next-state logic. Ready is reloaded on the same edge the skid drains,
  // so input resumes in the cycle right after the skid beat leaves.
  always_comb begin
    w_state_next    = r_state;
    w_in_ready_next = r_in_ready;
    case (r_state)
      ST_PASS: begin
        if (w_skid_load) begin
          w_state_next    = ST_SKID;
          w_in_ready_next = 1'b0;
        end else begin
          w_in_ready_next = 1'b1;
        end
      end
      ST_SKID: begin
        if (pipe_out_ready) begin
          w_state_next    = ST_PASS;
          w_in_ready_next = 1'b1;
        end else begin
          w_in_ready_next = 1'b0;
        end
      end
      default: begin
        w_state_next    = ST_PASS;
        w_in_ready_next = 1'b0;
      end
    endcase
  end

  // Output logic: zero-latency pass-through in PASS, skid contents in SKID.
  always_comb begin
    pipe_out_valid = 1'b0;
    pipe_out_data  = pipe_in_data;
    case (r_state)
      ST_PASS: begin
        pipe_out_valid = w_in_xfer;
        pipe_out_data  = pipe_in_data;
      end
      ST_SKID: begin
        pipe_out_valid = 1'b1;
        pipe_out_data  = r_skid_data;
      end
      default: begin
        pipe_out_valid = 1'b0;
        pipe_out_data  = pipe_in_data;
      end
    endcase
  end

  // Skid payload: loaded only on capture, otherwise held. It has no reset
  // because it is never observed unless the state is SKID.
  always_ff @(posedge clk) begin
    if (w_skid_load) begin
      r_skid_data <= pipe_in_data;
    end
  end

  // Saturating count of clock edges spent in SKID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_SKID) && !w_cnt_max) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign pipe_in_ready = r_in_ready;
  assign skid_full     = (r_state == ST_SKID);
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_s2m_pipe.sv
// Testbench for s2m_pipe: scoreboard-based checks of pass-through, skid capture,
// back-to-back release, reset mid-stall, counter saturation and random traffic.
module tb_s2m_pipe;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pipe_in_valid = 1'b0;
  logic [DW-1:0] pipe_in_data = '0;
  logic          pipe_out_ready = 1'b0;
  logic          pipe_in_ready;
  logic          pipe_out_valid;
  logic [DW-1:0] pipe_out_data;
  logic          skid_full;
  logic [15:0]   stall_cnt;

  logic          d4_in_ready;
  logic          d4_out_valid;
  logic [7:0]    d4_out_data;
  logic          d4_skid_full;
  logic [3:0]    d4_stall_cnt;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  s2m_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .pipe_in_valid(pipe_in_valid), .pipe_in_data(pipe_in_data), .pipe_in_ready(pipe_in_ready),
    .pipe_out_valid(pipe_out_valid), .pipe_out_data(pipe_out_data), .pipe_out_ready(pipe_out_ready),
    .skid_full(skid_full), .stall_cnt(stall_cnt)
  );

  s2m_pipe #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .pipe_in_valid(pipe_in_valid), .pipe_in_data(pipe_in_data[7:0]), .pipe_in_ready(d4_in_ready),
    .pipe_out_valid(d4_out_valid), .pipe_out_data(d4_out_data), .pipe_out_ready(pipe_out_ready),
    .skid_full(d4_skid_full), .stall_cnt(d4_stall_cnt)
  );

  // Hold reset for two edges, release it, then wait the one edge ready needs.
  task automatic do_reset();
    pipe_in_valid = 1'b0; pipe_out_ready = 1'b0; pipe_in_data = '0; reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    pipe_in_valid = 1'b1; pipe_in_data = 32'h5A; pipe_out_ready = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (pipe_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0b want 0", pipe_in_ready); end
    n_cmp++; if (pipe_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", pipe_out_valid); end
    n_cmp++; if (skid_full !== 1'b0) begin n_err++; $display("FAIL reset_skid_full: got %0b want 0", skid_full); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (pipe_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_first_cycle_ready: got %0b want 0", pipe_in_ready); end
    n_cmp++; if (pipe_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_first_cycle_valid: got %0b want 0", pipe_out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (pipe_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_rise: got %0b want 1", pipe_in_ready); end
    pipe_in_valid = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_stream();
    int k = 1;
    logic acc;
    logic [DW-1:0] exp_d;
    pipe_in_valid = 1'b0; pipe_out_ready = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    for (int cyc = 0; cyc < 40 && k <= 8; cyc++) begin
      pipe_in_valid = 1'b1; pipe_in_data = DW'(k); pipe_out_ready = 1'b1;
      @(negedge clk);
      if (cyc == 0) begin
        n_cmp++; if (pipe_in_ready !== 1'b0) begin n_err++; $display("FAIL stream_first_ready: got %0b want 0", pipe_in_ready); end
      end
      acc = pipe_in_valid && pipe_in_ready;
      if (acc) begin
        sb_q.push_back(pipe_in_data);
        n_cmp++;
        if (pipe_out_valid !== 1'b1 || pipe_out_data !== DW'(k)) begin
          n_err++; $display("FAIL stream_zero_latency: got v=%0b d=%0h want v=1 d=%0h", pipe_out_valid, pipe_out_data, k);
        end
      end
      if (pipe_out_valid && pipe_out_ready) begin
        n_cmp++;
        if (sb_q.size() == 0) begin n_err++; $display("FAIL stream_sb: got %0h want nothing", pipe_out_data); end
        else begin
          exp_d = sb_q.pop_front();
          if (pipe_out_data !== exp_d) begin n_err++; $display("FAIL stream_sb: got %0h want %0h", pipe_out_data, exp_d); end
        end
      end
      @(posedge clk); #1;
      if (acc) k++;
    end
    pipe_in_valid = 1'b0;
    n_cmp++; if (k != 9) begin n_err++; $display("FAIL stream_timeout: got %0d beats want 8", k - 1); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL stream_stall_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL stream_leftover: got %0d want 0", sb_q.size()); end
    $display("test_stream done: %0d beats", k - 1);
  endtask

  task automatic test_skid();
    int outs = 0;
    logic [DW-1:0] exp_d;
    do_reset();
    pipe_in_valid = 1'b1; pipe_in_data = 32'hA5; pipe_out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (pipe_in_ready !== 1'b1 || pipe_out_valid !== 1'b1) begin
      n_err++; $display("FAIL skid_capture_cycle: got rdy=%0b v=%0b want 1 1", pipe_in_ready, pipe_out_valid); end
    if (pipe_in_valid && pipe_in_ready) sb_q.push_back(pipe_in_data);
    @(posedge clk); #1;
    pipe_in_valid = 1'b0; pipe_in_data = '0;
    for (int c = 1; c <= 4; c++) begin
      pipe_out_ready = (c >= 3);
      @(negedge clk);
      if (c <= 3) begin
        n_cmp++; if ({skid_full, pipe_in_ready, pipe_out_valid} !== 3'b101 || pipe_out_data !== 32'hA5) begin
          n_err++; $display("FAIL skid_hold c%0d: got full/rdy/v=%b d=%0h want 101 d=a5", c, {skid_full, pipe_in_ready, pipe_out_valid}, pipe_out_data); end
      end else begin
        n_cmp++; if ({skid_full, pipe_in_ready, pipe_out_valid} !== 3'b010) begin
          n_err++; $display("FAIL skid_drained: got full/rdy/v=%b want 010", {skid_full, pipe_in_ready, pipe_out_valid}); end
      end
      if (pipe_out_valid && pipe_out_ready) begin
        outs++;
        n_cmp++;
        if (sb_q.size() == 0) begin n_err++; $display("FAIL skid_sb: got %0h want nothing", pipe_out_data); end
        else begin
          exp_d = sb_q.pop_front();
          if (pipe_out_data !== exp_d) begin n_err++; $display("FAIL skid_sb: got %0h want %0h", pipe_out_data, exp_d); end
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (outs != 1) begin n_err++; $display("FAIL skid_once: got %0d outputs want 1", outs); end
    n_cmp++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL skid_stall_cnt: got %0d want 3", stall_cnt); end
    $display("test_skid done: stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d;
    do_reset();
    pipe_in_valid = 1'b1; pipe_in_data = 32'h11; pipe_out_ready = 1'b0;
    @(negedge clk);
    if (pipe_in_valid && pipe_in_ready) sb_q.push_back(pipe_in_data);
    @(posedge clk); #1;
    pipe_in_data = 32'h22; pipe_out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (pipe_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_not_accepted: got rdy=%0b want 0", pipe_in_ready); end
    if (pipe_in_valid && pipe_in_ready) sb_q.push_back(pipe_in_data);
    n_cmp++;
    if (!(pipe_out_valid && pipe_out_ready) || sb_q.size() == 0) begin
      n_err++; $display("FAIL b2b_skid_out: got v=%0b q=%0d want v=1 q>0", pipe_out_valid, sb_q.size()); end
    else begin
      exp_d = sb_q.pop_front();
      if (pipe_out_data !== exp_d || exp_d !== 32'h11) begin n_err++; $display("FAIL b2b_skid_out: got %0h want 11", pipe_out_data); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (pipe_in_ready !== 1'b1 || skid_full !== 1'b0) begin
      n_err++; $display("FAIL b2b_resume: got rdy=%0b full=%0b want 1 0", pipe_in_ready, skid_full); end
    if (pipe_in_valid && pipe_in_ready) sb_q.push_back(pipe_in_data);
    n_cmp++;
    if (!(pipe_out_valid && pipe_out_ready) || sb_q.size() == 0) begin
      n_err++; $display("FAIL b2b_next_out: got v=%0b q=%0d want v=1 q>0", pipe_out_valid, sb_q.size()); end
    else begin
      exp_d = sb_q.pop_front();
      if (pipe_out_data !== exp_d || exp_d !== 32'h22) begin n_err++; $display("FAIL b2b_next_out: got %0h want 22", pipe_out_data); end
    end
    @(posedge clk); #1;
    pipe_in_valid = 1'b0;
    n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL b2b_leftover: got %0d want 0", sb_q.size()); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_skid();
    do_reset();
    pipe_in_valid = 1'b1; pipe_in_data = 32'h33; pipe_out_ready = 1'b0;
    @(posedge clk); #1;
    pipe_in_valid = 1'b0; pipe_in_data = '0;
    @(negedge clk);
    n_cmp++; if (skid_full !== 1'b1) begin n_err++; $display("FAIL midrst_pre_full: got %0b want 1", skid_full); end
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (pipe_out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %0b want 0", pipe_out_valid); end
    n_cmp++; if (skid_full !== 1'b0) begin n_err++; $display("FAIL midrst_full: got %0b want 0", skid_full); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_stall_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if (pipe_in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %0b want 0", pipe_in_ready); end
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0; pipe_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (pipe_out_valid !== 1'b0) begin
        n_err++; $display("FAIL midrst_replay c%0d: got v=%0b d=%0h want v=0", c, pipe_out_valid, pipe_out_data); end
      @(posedge clk); #1;
    end
    $display("test_reset_mid_skid done");
  endtask

  task automatic test_saturate();
    logic [3:0] exp_c;
    do_reset();
    pipe_in_valid = 1'b1; pipe_in_data = 32'h5C; pipe_out_ready = 1'b0;
    @(posedge clk); #1;
    pipe_in_valid = 1'b0;
    for (int j = 1; j <= 21; j++) begin
      @(negedge clk);
      exp_c = (j - 1 > 15) ? 4'd15 : 4'(j - 1);
      n_cmp++; if (d4_stall_cnt !== exp_c || d4_skid_full !== 1'b1) begin
        n_err++; $display("FAIL sat_cnt j%0d: got cnt=%0d full=%0b want cnt=%0d full=1", j, d4_stall_cnt, d4_skid_full, exp_c); end
      @(posedge clk); #1;
    end
    n_cmp++; if (d4_stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_final: got %0d want 15", d4_stall_cnt); end
    n_cmp++; if (stall_cnt !== 16'd21) begin n_err++; $display("FAIL sat_wide_cnt: got %0d want 21", stall_cnt); end
    pipe_out_ready = 1'b1;
    @(posedge clk); #1;
    $display("test_saturate done: cnt4=%0d cnt16=%0d", d4_stall_cnt, stall_cnt);
  endtask

  task automatic test_random();
    int accepted = 0;
    int cyc = 0;
    int m_stall = 0;
    logic m_skid = 1'b0;
    logic acc;
    logic r0;
    logic prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] next_val = 32'h1000;
    logic [DW-1:0] exp_d;
    do_reset();
    while ((accepted < 10000 || sb_q.size() != 0) && cyc < 60000) begin
      pipe_in_valid  = (accepted < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      pipe_in_data   = next_val;
      pipe_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++; if (skid_full !== m_skid || pipe_in_ready !== !m_skid) begin
        n_err++; $display("FAIL rnd_state cyc%0d: got full=%0b rdy=%0b want full=%0b rdy=%0b", cyc, skid_full, pipe_in_ready, m_skid, !m_skid); end
      if (prev_hold) begin
        n_cmp++; if (pipe_out_valid !== 1'b1 || pipe_out_data !== prev_data) begin
          n_err++; $display("FAIL rnd_hold cyc%0d: got v=%0b d=%0h want v=1 d=%0h", cyc, pipe_out_valid, pipe_out_data, prev_data); end
      end
      acc = pipe_in_valid && !m_skid;
      if (acc) sb_q.push_back(pipe_in_data);
      if (pipe_out_valid && pipe_out_ready) begin
        n_cmp++;
        if (sb_q.size() == 0) begin n_err++; $display("FAIL rnd_sb cyc%0d: got %0h want nothing", cyc, pipe_out_data); end
        else begin
          exp_d = sb_q.pop_front();
          if (pipe_out_data !== exp_d) begin n_err++; $display("FAIL rnd_sb cyc%0d: got %0h want %0h", cyc, pipe_out_data, exp_d); end
        end
      end
      prev_hold = pipe_out_valid && !pipe_out_ready;
      prev_data = pipe_out_data;
      r0 = pipe_in_ready;
      pipe_out_ready = !pipe_out_ready; #1;
      n_cmp++; if (pipe_in_ready !== r0) begin n_err++; $display("FAIL rnd_ready_comb cyc%0d: got %0b want %0b", cyc, pipe_in_ready, r0); end
      pipe_out_ready = !pipe_out_ready; #1;
      if (m_skid) m_stall++;
      m_skid = m_skid ? !pipe_out_ready : (acc && !pipe_out_ready);
      @(posedge clk); #1;
      if (acc) begin accepted++; next_val++; end
      cyc++;
    end
    pipe_in_valid = 1'b0; pipe_out_ready = 1'b0;
    n_cmp++; if (cyc >= 60000) begin n_err++; $display("FAIL rnd_timeout: got %0d accepted %0d queued want 10000 0", accepted, sb_q.size()); end
    n_cmp++; if (stall_cnt !== 16'(m_stall)) begin n_err++; $display("FAIL rnd_stall_cnt: got %0d want %0d", stall_cnt, m_stall); end
    $display("test_random done: %0d beats in %0d cycles", accepted, cyc);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_back_to_back();
    test_reset_mid_skid();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
